// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed byte stream into 18-bit words,
// writes them to instruction memory from address 0, and releases CPU reset once the checksum verifies.
module prog_loader #(
  parameter int INSTRUCTION_WIDTH = 18,
  parameter int ADDRESS_BUS_WIDTH = 14
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [7:0]                   i_byte,
  input  logic                         i_byte_valid,
  output logic                         o_byte_ready,
  output logic                         o_mem_write,
  output logic [ADDRESS_BUS_WIDTH-1:0] o_mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] o_mem_wdata,
  output logic                         o_cpu_rst,
  output logic                         o_done,
  output logic                         o_error
);

  localparam int CW = ADDRESS_BUS_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_BUS_WIDTH;

  typedef enum logic [3:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]                  r_len;
  logic [CW-1:0]                r_addr;
  logic [7:0]                   r_csum;
  logic [7:0]                   r_b0;
  logic [7:0]                   r_b1;
  logic                         r_mem_write;
  logic [INSTRUCTION_WIDTH-1:0] r_wdata;
  logic                         r_cpu_rst;
  logic                         r_done;
  logic                         r_error;

  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_len_in;
  logic        w_oversize;
  logic        w_b2_bad;
  logic        w_last_word;
  logic        w_csum_ok;
  logic [17:0] w_word;

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CSUM, S_ERROR: w_ready = 1'b1;
      default:                                              w_ready = 1'b0;
    endcase
  end

  assign o_byte_ready = w_ready && !i_rst;
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_len_in     = {i_byte, r_len[7:0]};
  assign w_oversize   = 17'(w_len_in) > MAX_WORDS;
  assign w_b2_bad     = i_byte[7:2] != 6'd0;
  // Counter is one bit wider than the address so a full 2^AW image still terminates.
  assign w_last_word  = (17'(r_addr) + 17'd1) == 17'(r_len);
  assign w_csum_ok    = r_csum == i_byte;
  assign w_word       = {i_byte[1:0], r_b1, r_b0};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_LEN_LO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len_in == 16'd0) w_next = S_CSUM;
          else if (w_oversize)   w_next = S_ERROR;
          else                   w_next = S_B0;
        end
      end
      S_B0:     if (w_accept) w_next = S_B1;
      S_B1:     if (w_accept) w_next = S_B2;
      S_B2:     if (w_accept) w_next = w_b2_bad ? S_ERROR : S_WRITE;
      S_WRITE:  w_next = w_last_word ? S_CSUM : S_B0;
      S_CSUM:   if (w_accept) w_next = w_csum_ok ? S_DONE : S_ERROR;
      S_DONE:   w_next = S_DONE;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len       <= '0;
      r_addr      <= '0;
      r_csum      <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_mem_write <= 1'b0;
      r_wdata     <= '0;
      r_cpu_rst   <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      unique case (r_state)
        S_LEN_LO: begin
          r_csum <= '0;
          r_addr <= '0;
          if (w_accept) r_len[7:0] <= i_byte;
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= i_byte;
            if (w_len_in != 16'd0 && w_oversize) r_error <= 1'b1;
          end
        end
        S_B0: begin
          if (w_accept) begin
            r_b0   <= i_byte;
            r_csum <= r_csum ^ i_byte;
          end
        end
        S_B1: begin
          if (w_accept) begin
            r_b1   <= i_byte;
            r_csum <= r_csum ^ i_byte;
          end
        end
        S_B2: begin
          if (w_accept) begin
            r_csum <= r_csum ^ i_byte;
            if (w_b2_bad) begin
              r_error <= 1'b1;
            end else begin
              r_mem_write <= 1'b1;
              r_wdata     <= INSTRUCTION_WIDTH'(w_word);
            end
          end
        end
        S_WRITE: r_addr <= r_addr + CW'(1);
        S_CSUM: begin
          if (w_accept) begin
            if (w_csum_ok) begin
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_addr[ADDRESS_BUS_WIDTH-1:0];
  assign o_mem_wdata = r_wdata;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a stream-level reference model queues expected
// memory writes; a negedge monitor pops and compares every write strobe.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write;
  logic [13:0] mem_addr;
  logic [17:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  prog_loader #(.INSTRUCTION_WIDTH(18), .ADDRESS_BUS_WIDTH(14)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_byte      (byte_in),
    .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready),
    .o_mem_write (mem_write),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_cpu_rst   (cpu_rst),
    .o_done      (done),
    .o_error     (error)
  );

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!rst && mem_write === 1'b1) begin
      check("ready_during_write", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), e.addr);
        check("write_data", 32'(mem_wdata), e.data);
      end
    end
  end

  // Reference model: parses the stream by its byte-level rules and queues the writes.
  task automatic model(input logic [7:0] s[$], output bit exp_done, output bit exp_err);
    int unsigned n;
    int unsigned x;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    x = 0;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > 16384) begin
      exp_err = 1'b1;
      return;
    end
    for (int unsigned w = 0; w < n; w++) begin
      int unsigned b0, b1, b2;
      b0 = s[2 + 3*w];
      b1 = s[3 + 3*w];
      b2 = s[4 + 3*w];
      x = x ^ b0 ^ b1 ^ b2;
      if (b2 > 3) begin
        exp_err = 1'b1;
        return;
      end
      exp_q.push_back('{addr: w, data: b2 * 65536 + b1 * 256 + b0});
    end
    if (int'(s[2 + 3*n]) == x) exp_done = 1'b1;
    else                       exp_err  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned t;
    t = 0;
    for (int unsigned g = 0; g < gap; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      check("handshake_timeout", 32'(byte_ready), 32'd1);
      return;
    end
    @(posedge clk);
  endtask

  // Sends the stream, then checks completion flags in the cycle after the last handshake.
  task automatic run_stream(input string tag, input logic [7:0] s[$], input int unsigned maxgap);
    bit ed, ee;
    model(s, ed, ee);
    foreach (s[i]) send_byte(s[i], $urandom_range(0, maxgap));
    @(negedge clk);
    byte_valid = 1'b0;
    check({tag, "_done"},    32'(done),       32'(ed));
    check({tag, "_error"},   32'(error),      32'(ee));
    check({tag, "_cpu_rst"}, 32'(cpu_rst),    32'(!ed));
    check({tag, "_ready"},   32'(byte_ready), 32'(!ed));
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"},  32'(done),  32'(ed));
    check({tag, "_error_hold"}, 32'(error), 32'(ee));
    check({tag, "_pending"},    32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'($urandom_range(0, 1));
    byte_in    = 8'($urandom);
    #1;
    check("ready_in_reset", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rst",   32'(cpu_rst),   32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    rst        = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("ready_after_reset", 32'(byte_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    s = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h03, 8'h64};
    run_stream("nominal", s, 0);
    do_reset();
    run_stream("gapped", s, 5);
    do_reset();

    s = '{8'h00, 8'h00, 8'h00};
    run_stream("zero_ok", s, 2);
    do_reset();
    s = '{8'h00, 8'h00, 8'h5A};
    run_stream("zero_bad", s, 2);
    do_reset();

    s = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h03, 8'h65};
    run_stream("bad_csum", s, 1);
    do_reset();

    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_stream("illegal_b2", s, 1);
    do_reset();

    // Abort after B1 of word 1: only word 0 may be written.
    exp_q.push_back('{addr: 0, data: 32'h12345});
    s = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF};
    foreach (s[i]) send_byte(s[i], 0);
    do_reset();
    repeat (2) @(negedge clk);
    check("midreset_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    s = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h03, 8'h64};
    run_stream("resend", s, 0);
    do_reset();

    s = '{8'h01, 8'h40, 8'h11, 8'h22, 8'h33};
    run_stream("oversize", s, 1);
    do_reset();

    for (int k = 0; k < 10; k++) begin
      int unsigned n;
      logic [7:0]  x;
      logic [7:0]  b;
      n = $urandom_range(1, 6);
      x = 8'h00;
      s = {};
      s.push_back(8'(n));
      s.push_back(8'h00);
      for (int unsigned w = 0; w < n; w++) begin
        for (int j = 0; j < 3; j++) begin
          b = 8'($urandom);
          if (j == 2) b = ($urandom_range(0, 15) == 0) ? (b | 8'h04) : (b & 8'h03);
          s.push_back(b);
          x = x ^ b;
        end
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      s.push_back(x);
      begin
        wr_t save[$];
        bit ed, ee;
        model(s, ed, ee);
        exp_q.delete();
        if (ee) begin
          s.push_back(8'($urandom));
          s.push_back(8'($urandom));
        end
        save = save;
      end
      run_stream("random", s, 5);
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the cpu/inst_mem pair. It receives a byte stream over a valid/ready handshake, assembles 18-bit instruction words, and writes them into instruction memory at consecutive addresses from 0. It holds the CPU in reset until the full image is loaded and its checksum verifies, then releases it.

## Interface
- INSTRUCTION_WIDTH, 18, instruction word width written to memory
- ADDRESS_BUS_WIDTH, 14, memory address width; max image = 2^14 words

- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_byte  input  8  incoming stream byte
- i_byte_valid  input  1  i_byte valid this cycle
- o_byte_ready  output  1  loader accepts a byte this cycle
- o_mem_write  output  1  one-cycle write strobe to instruction memory
- o_mem_addr  output  ADDRESS_BUS_WIDTH  write address
- o_mem_wdata  output  INSTRUCTION_WIDTH  write data
- o_cpu_rst  output  1  hold-reset to CPU; 1 until successful load
- o_done  output  1  image loaded and verified (sticky)
- o_error  output  1  protocol/checksum failure (sticky until i_rst)

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N × 3 bytes per word (B0 = bits 7:0, B1 = bits 15:8, B2 = bits 17:16 in B2[1:0]), then one checksum byte = XOR of all 3N word bytes (length bytes excluded).
- Byte accepted only on cycle with i_byte_valid && o_byte_ready.
- States: LEN_LO → LEN_HI → (N==0: CSUM; 1 ≤ N ≤ 16384: B0; N > 16384: ERROR) ; B0 → B1 → B2 → WRITE → (words remaining: B0; else CSUM) ; CSUM → (match: DONE; mismatch: ERROR).
- B2 with B2[7:2] ≠ 0 → ERROR; no write issued for that word.
- WRITE: o_mem_write = 1 for exactly one cycle, o_mem_addr = current word index, o_mem_wdata = assembled word; address counter increments after write. Address counter is 15 bits internally so N = 16384 terminates correctly; o_mem_addr carries low 14 bits.
- o_byte_ready: 0 while i_rst = 1; otherwise 1 in LEN_LO, LEN_HI, B0, B1, B2, CSUM, ERROR (ERROR drains and discards input); 0 in WRITE and DONE.
- DONE: o_done = 1, o_cpu_rst = 0, no further writes; held until i_rst.
- ERROR: o_error = 1, o_cpu_rst = 1; words already written stay in memory; held until i_rst.
- Running XOR checksum and word counter cleared in LEN_LO.

## Timing
- Reset values (cycle after i_rst sampled high): state LEN_LO, o_mem_write 0, o_mem_addr 0, o_mem_wdata 0, o_cpu_rst 1, o_done 0, o_error 0, o_byte_ready 0 while i_rst held.
- i_rst asserted mid-load: aborts immediately next edge; pending WRITE not issued; o_cpu_rst re-asserts; o_done/o_error clear.
- All outputs except o_byte_ready are registered.
- Write latency: o_mem_write high in the cycle after the B2 handshake.
- Gap-free stream costs 4 cycles/word (3 bytes + WRITE).
- o_done / o_error assert in the cycle after the checksum handshake (or after the offending byte); o_cpu_rst deasserts in the same cycle as o_done.
- Zero-length image: LEN 00 00, checksum 00 → DONE with no writes; checksum ≠ 00 → ERROR.

## Test plan
- Nominal: bytes 02 00 45 23 01 FF FF 03 64 → writes addr0 = 0x12345, addr1 = 0x3FFFF, one strobe each; o_done = 1, o_cpu_rst = 0.
- Gapped valid: same stream with random 0–5 cycle gaps on i_byte_valid → identical writes and completion; no byte accepted during WRITE.
- Zero length: 00 00 00 → DONE, no o_mem_write; 00 00 5A → o_error = 1, o_cpu_rst stays 1.
- Bad checksum: nominal stream with final byte 65 → both words written, o_error = 1, o_done = 0, o_cpu_rst = 1.
- Illegal B2: 01 00 00 00 04 → ERROR after the B2 handshake, no write; subsequent bytes accepted and discarded.
- Reset mid-load: i_rst pulsed after the B1 of word 1 → no write for that word; nominal stream resent → correct load from addr 0; oversize LEN 01 40 (16385) → ERROR.
